// File: rtl/ov7670_cap_pkg.sv
// Shared types and constants for the OV7670 capture/decimation path.
// Holds the FSM state type, default geometry and RGB565 field positions.
package ov7670_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        DONE
    } cap_state_t;

    localparam int unsigned SRC_X_DEF  = 640;
    localparam int unsigned SRC_Y_DEF  = 480;
    localparam int unsigned DEC_DEF    = 8;
    localparam int unsigned DST_X_DEF  = 80;
    localparam int unsigned DST_Y_DEF  = 60;
    localparam int unsigned ADDR_W_DEF = 13;

    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    // Byte 0 carries {R, G[5:3]}, byte 1 carries {G[2:0], B}.
    function automatic logic [15:0] rgb565_pack(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] p;
        p = '0;
        p[R_MSB:R_LSB] = b0[7:3];
        p[G_MSB:G_LSB] = {b0[2:0], b1[7:5]};
        p[B_MSB:B_LSB] = b1[4:0];
        return p;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with rise/fall detect against the value held at the
// previous sample strobe (sample tied high gives plain per-clock edge detect).
module cam_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         sample,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise_c,
    output logic [W-1:0] fall_c
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (sample) begin
                s3 <= s2;
            end
        end
    end

    assign sync   = s2;
    assign rise_c = {W{sample}} & s2 & ~s3;
    assign fall_c = {W{sample}} & ~s2 & s3;

endmodule

// File: rtl/ov7670_capture_decimator.sv
// Oversamples the OV7670 RGB565 byte stream, keeps every C_DEC-th pixel of
// every C_DEC-th line and writes it in raster order into the frame buffer.
module ov7670_capture_decimator
    import ov7670_cap_pkg::*;
#(
    parameter int unsigned C_SRC_X  = SRC_X_DEF,
    parameter int unsigned C_SRC_Y  = SRC_Y_DEF,
    parameter int unsigned C_DEC    = DEC_DEF,
    parameter int unsigned C_DST_X  = DST_X_DEF,
    parameter int unsigned C_DST_Y  = DST_Y_DEF,
    parameter int unsigned C_ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cam_pclk,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_d,
    input  logic                capture_en,
    output logic                wr_en,
    output logic [C_ADDR_W-1:0] wr_addr,
    output logic [15:0]         wr_data,
    output logic                frame_done,
    output logic                frame_err
);

    // Counters saturate one past the nominal size so oversize lines stay visible.
    localparam int unsigned X_W   = $clog2(C_SRC_X + 2);
    localparam int unsigned Y_W   = $clog2(C_SRC_Y + 2);
    localparam int unsigned DEC_W = $clog2(C_DEC);
    localparam int unsigned N_PIX = C_DST_X * C_DST_Y;

    logic       pclk_rise;
    logic       pclk_sync_unused;
    logic       pclk_fall_unused;
    logic       href_s;
    logic       href_rise;
    logic       href_fall;
    logic       vs_sync_unused;
    logic       vs_rise;
    logic       vs_fall;
    logic [7:0] d_s;
    logic [7:0] d_rise_unused;
    logic [7:0] d_fall_unused;

    cam_sync_edge #(.W(1)) u_pclk (
        .clk(clk), .reset(reset), .din(cam_pclk), .sample(1'b1),
        .sync(pclk_sync_unused), .rise_c(pclk_rise), .fall_c(pclk_fall_unused)
    );

    cam_sync_edge #(.W(1)) u_href (
        .clk(clk), .reset(reset), .din(cam_href), .sample(pclk_rise),
        .sync(href_s), .rise_c(href_rise), .fall_c(href_fall)
    );

    cam_sync_edge #(.W(1)) u_vsync (
        .clk(clk), .reset(reset), .din(cam_vsync), .sample(pclk_rise),
        .sync(vs_sync_unused), .rise_c(vs_rise), .fall_c(vs_fall)
    );

    cam_sync_edge #(.W(8)) u_data (
        .clk(clk), .reset(reset), .din(cam_d), .sample(1'b1),
        .sync(d_s), .rise_c(d_rise_unused), .fall_c(d_fall_unused)
    );

    cap_state_t          state;
    logic [X_W-1:0]      x_cnt;
    logic [Y_W-1:0]      y_cnt;
    logic                phase;
    logic [7:0]          hi_byte;
    logic [C_ADDR_W-1:0] dst_cnt;
    logic                dst_full;
    logic                err_acc;

    logic           byte0_c;
    logic           pix_done_c;
    logic           in_range_c;
    logic           on_grid_c;
    logic           do_wr_c;
    logic           line_err_c;
    logic [Y_W-1:0] y_next_c;

    assign byte0_c    = pclk_rise & href_s & (href_rise | ~phase);
    assign pix_done_c = pclk_rise & href_s & ~href_rise & phase;
    assign in_range_c = (x_cnt < X_W'(C_SRC_X)) && (y_cnt < Y_W'(C_SRC_Y));
    assign on_grid_c  = (x_cnt[DEC_W-1:0] == '0) && (y_cnt[DEC_W-1:0] == '0);
    assign do_wr_c    = pix_done_c & in_range_c & on_grid_c & ~dst_full & ~vs_rise;
    assign line_err_c = href_fall & (phase | (x_cnt != X_W'(C_SRC_X)));
    assign y_next_c   = (href_fall && (y_cnt <= Y_W'(C_SRC_Y))) ? y_cnt + Y_W'(1) : y_cnt;

    // Capture FSM, line/pixel counters and buffer write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            dst_cnt    <= '0;
            dst_full   <= 1'b0;
            err_acc    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (vs_fall) begin
                        if (capture_en) begin
                            x_cnt     <= '0;
                            y_cnt     <= '0;
                            phase     <= 1'b0;
                            dst_cnt   <= '0;
                            dst_full  <= 1'b0;
                            err_acc   <= 1'b0;
                            frame_err <= 1'b0;
                            state     <= ACTIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ACTIVE: begin
                    if (byte0_c) begin
                        hi_byte <= d_s;
                        phase   <= 1'b1;
                    end
                    if (pix_done_c) begin
                        phase <= 1'b0;
                        if (x_cnt <= X_W'(C_SRC_X)) begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                    end
                    if (do_wr_c) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dst_cnt;
                        wr_data <= rgb565_pack(hi_byte, d_s);
                        if (dst_cnt == C_ADDR_W'(N_PIX - 1)) begin
                            dst_full <= 1'b1;
                        end else begin
                            dst_cnt <= dst_cnt + C_ADDR_W'(1);
                        end
                    end
                    // A partial pixel at line end is simply dropped with the phase reset.
                    if (href_fall) begin
                        x_cnt   <= '0;
                        y_cnt   <= y_next_c;
                        phase   <= 1'b0;
                        err_acc <= err_acc | line_err_c;
                    end
                    if (vs_rise) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_err  <= err_acc | line_err_c | (y_next_c != Y_W'(C_SRC_Y));
                    end
                end
                DONE: begin
                    state <= WAIT_SOF;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_decimator.sv
// Directed bench for ov7670_capture_decimator on a reduced 32x24 /4 geometry,
// driving camera pins at clk/4 and scoreboarding the buffer write port.
module tb_ov7670_capture_decimator;

    localparam int unsigned SX  = 32;
    localparam int unsigned SY  = 24;
    localparam int unsigned DEC = 4;
    localparam int unsigned DX  = 8;
    localparam int unsigned DY  = 6;
    localparam int unsigned AW  = 6;
    localparam int unsigned NP  = DX * DY;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_d = 8'h00;
    logic          capture_en = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          frame_err;

    ov7670_capture_decimator #(
        .C_SRC_X(SX), .C_SRC_Y(SY), .C_DEC(DEC),
        .C_DST_X(DX), .C_DST_Y(DY), .C_ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .capture_en(capture_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Write-port monitor; cleared on request from the stimulus thread.
    int          clr_req = 0;
    int          clr_ack = 0;
    int          n_wr, n_done, n_bad, n_dup, n_consec, n_overlap;
    logic        err_at_done;
    logic        prev_wr;
    logic [15:0] mem [NP];
    logic        hit [NP];

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            clr_ack     <= clr_req;
            n_wr        <= 0;
            n_done      <= 0;
            n_bad       <= 0;
            n_dup       <= 0;
            n_consec    <= 0;
            n_overlap   <= 0;
            err_at_done <= 1'b0;
            prev_wr     <= 1'b0;
            for (int a = 0; a < NP; a++) begin
                mem[a] <= 16'hFFFF;
                hit[a] <= 1'b0;
            end
        end else begin
            prev_wr <= wr_en;
            if (wr_en) begin
                n_wr <= n_wr + 1;
                if (prev_wr) n_consec <= n_consec + 1;
                if (frame_done) n_overlap <= n_overlap + 1;
                if (int'(wr_addr) >= NP) begin
                    n_bad <= n_bad + 1;
                end else begin
                    if (hit[wr_addr]) n_dup <= n_dup + 1;
                    hit[wr_addr] <= 1'b1;
                    mem[wr_addr] <= wr_data;
                end
            end
            if (frame_done) begin
                n_done      <= n_done + 1;
                err_at_done <= frame_err;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int x, input int y);
        logic [7:0] xv;
        logic [7:0] yv;
        xv = 8'(x);
        yv = 8'(y);
        return {xv[4:0], yv[5:0], xv[7:3]};
    endfunction

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One camera byte: pclk low for 2 clk (data changes here), high for 2 clk.
    task automatic pclk_cycle(input logic [7:0] b, input logic h, input logic v);
        @(negedge clk);
        cam_d     = b;
        cam_href  = h;
        cam_vsync = v;
        cam_pclk  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_line(input int y, input int nb);
        logic [15:0] p;
        for (int i = 0; i < nb; i++) begin
            p = pix(i / 2, y);
            pclk_cycle((i % 2 == 0) ? p[15:8] : p[7:0], 1'b1, 1'b0);
        end
        repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nx, input int ny, input int odd_line, input int drop_line);
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b0);
        for (int y = 0; y < ny; y++) begin
            if (y == drop_line) capture_en = 1'b0;
            send_line(y, (y == odd_line) ? 2 * nx - 1 : 2 * nx);
        end
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int exp_wr, input int exp_done, input logic exp_err);
        int nbad_data;
        check({tag, " writes"}, 32'(n_wr), 32'(exp_wr));
        check({tag, " frame_done count"}, 32'(n_done), 32'(exp_done));
        check({tag, " addr out of range"}, 32'(n_bad), 32'd0);
        check({tag, " duplicate addr"}, 32'(n_dup), 32'd0);
        check({tag, " back-to-back wr_en"}, 32'(n_consec), 32'd0);
        check({tag, " wr_en with frame_done"}, 32'(n_overlap), 32'd0);
        if (exp_done > 0) begin
            check({tag, " frame_err at done"}, 32'(err_at_done), 32'(exp_err));
            check({tag, " frame_err held"}, 32'(frame_err), 32'(exp_err));
        end
        if (exp_wr == int'(NP)) begin
            nbad_data = 0;
            for (int a = 0; a < int'(NP); a++) begin
                if (mem[a] !== pix((a % DX) * DEC, (a / DX) * DEC)) nbad_data++;
            end
            check({tag, " wrong pixel count"}, 32'(nbad_data), 32'd0);
            check({tag, " addr 9 (x=4,y=4)"}, 32'(mem[9]), 32'h2080);
            check({tag, " addr 47 (x=28,y=20)"}, 32'(mem[47]), 32'hE283);
            check({tag, " addr 47 written"}, 32'(hit[47]), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset outputs", {7'd0, wr_en, frame_done, frame_err, wr_addr, wr_data}, 32'd0);
        reset = 1'b0;
        clear_mon();

        // Clean full frame.
        send_frame(SX, SY, -1, -1);
        check_frame("clean", NP, 1, 1'b0);

        // Reset mid-line at y=10, then a full frame.
        clear_mon();
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b0);
        for (int y = 0; y < 10; y++) send_line(y, 2 * SX);
        for (int i = 0; i < 20; i++) pclk_cycle(8'hA5, 1'b1, 1'b0);
        check("pre-reset wr_data nonzero", 32'(wr_data != 16'h0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid-frame reset outputs", {7'd0, wr_en, frame_done, frame_err, wr_addr, wr_data}, 32'd0);
        check("aborted frame no done", 32'(n_done), 32'd0);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        send_frame(SX, SY, -1, -1);
        check_frame("after reset", NP, 1, 1'b0);

        // Odd byte count on line 17.
        clear_mon();
        send_frame(SX, SY, 17, -1);
        check_frame("odd line", NP, 1, 1'b1);

        // Following clean frame clears the error.
        clear_mon();
        send_frame(SX, SY, -1, -1);
        check_frame("clean after odd", NP, 1, 1'b0);

        // capture_en low before start: nothing captured.
        clear_mon();
        capture_en = 1'b0;
        send_frame(SX, 4, -1, -1);
        check_frame("capture off", 0, 0, 1'b0);

        // Drop capture_en mid-frame: frame completes, next one skipped.
        capture_en = 1'b1;
        clear_mon();
        send_frame(SX, SY, -1, 5);
        check_frame("drop mid-frame", NP, 1, 1'b0);
        clear_mon();
        send_frame(SX, 4, -1, -1);
        check_frame("frame after drop", 0, 0, 1'b0);

        // Oversized 40x30 frame.
        capture_en = 1'b1;
        clear_mon();
        send_frame(40, 30, -1, -1);
        check_frame("oversized", NP, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
